rpc_refresh_scheduler: RTL and testbench
========================================

Name: rpc_refresh_scheduler

Overview:
- Sits between the periodic refresh timer, the host command front-end and the single command port of cmd_fsm.
- Counts refresh ticks into a postponement budget and arbitrates host commands against refresh commands.
- Issues one command at a time to cmd_fsm and waits for completion before issuing the next.
- Forces refresh priority once the backlog reaches an urgency threshold.

Parameters:
- CMD_WIDTH, 19: width of the command word presented to cmd_fsm.
- CNT_WIDTH, 4: width of the pending-refresh counter; must satisfy 2**CNT_WIDTH > MAX_POSTPONE.
- MAX_POSTPONE, 8: saturation value of the pending-refresh counter.
- URGENT_THRESH, 4: pending count at or above which refresh has priority and host commands are blocked; 1 <= URGENT_THRESH <= MAX_POSTPONE.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- init_done_i  in  1  single-cycle pulse from cmd_fsm when DRAM initialization completes.
- ref_tick_i  in  1  single-cycle refresh-due pulse from the refresh timer.
- host_valid_i  in  1  host command valid.
- host_cmd_i  in  CMD_WIDTH  host command word.
- host_ready_o  out  1  host command accepted when both host_valid_i and host_ready_o are high.
- fsm_valid_o  out  1  command valid toward cmd_fsm.
- fsm_cmd_o  out  CMD_WIDTH  command word toward cmd_fsm.
- fsm_is_ref_o  out  1  high when fsm_cmd_o is a refresh.
- fsm_ready_i  in  1  cmd_fsm accepts the command.
- fsm_done_i  in  1  single-cycle pulse when cmd_fsm finishes the accepted command.
- ref_pending_o  out  CNT_WIDTH  current pending-refresh count.
- ref_overrun_o  out  1  sticky flag: a tick arrived while the counter was saturated.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending count 0, init flag 0, command register 0.
- Init flag:
  - set by init_done_i; stays set until reset.
  - ref_tick_i is ignored while the flag is 0.
  - host_ready_o is 0 while the flag is 0.
- Pending counter:
  - tick only: +1.
  - refresh issue handshake (fsm_valid_o, fsm_ready_i and fsm_is_ref_o all high) only: -1.
  - tick and refresh issue handshake in the same cycle: count unchanged.
  - tick while count == MAX_POSTPONE and no issue handshake: count stays at MAX_POSTPONE and ref_overrun_o is set. It is cleared only by reset.
  - The counter never wraps or underflows.
- host_ready_o = (state == IDLE) and init flag and (pending < URGENT_THRESH). It does not depend on host_valid_i.
- State machine: IDLE, ISSUE, WAIT_DONE.
- IDLE, decisions in priority order:
  - If pending >= URGENT_THRESH: load REF_CMD, set is_ref, go to ISSUE.
  - Else if host handshake: latch host_cmd_i, clear is_ref, go to ISSUE.
  - Else if init flag and pending > 0: load REF_CMD (opportunistic refresh), go to ISSUE.
- ISSUE:
  - fsm_valid_o = 1; fsm_cmd_o and fsm_is_ref_o hold stable until fsm_ready_i.
  - On fsm_ready_i, go to WAIT_DONE; fsm_valid_o drops the next cycle.
- WAIT_DONE:
  - fsm_valid_o = 0.
  - On fsm_done_i, go to IDLE; the next decision is made in the cycle after.
  - fsm_done_i outside WAIT_DONE is ignored.
- Latency:
  - host handshake at cycle T -> fsm_valid_o high at T+1.
  - Minimum spacing between two fsm_valid_o rises is 3 cycles.
- Reset mid-operation: an in-flight command is dropped and the pending count is lost. cmd_fsm is reset by the same rst_i.
- Ticks are counted in every state, not only IDLE.

Optional Feature:
- Macro RPC_REFRESH_SCHED_STATS_EN.
- When defined: adds outputs host_issued_o [15:0] and ref_issued_o [15:0].
  - Each increments on its respective issue handshake.
  - Each wraps modulo 2**16.
  - Both reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- rpc_config_path_pkg gets:
  - REF_CMD (CMD_WIDTH-bit refresh encoding).
  - The state typedef refresh_sched_state_t.
  - Defaults for MAX_POSTPONE and URGENT_THRESH.
- One sub-module: rpc_pending_cnt (saturating up/down counter with sticky overrun flag). The arbiter FSM stays in the top module.

Test Plan:
- Ticks before init_done_i:
  - Stimulus: 3 ref_tick_i pulses before init_done_i.
  - Required: ref_pending_o = 0, host_ready_o = 0.
  - Then pulse init_done_i with host_valid_i = 1 and host_cmd_i = 19'h1234.
  - Required: fsm_valid_o rises 1 cycle after the handshake with fsm_cmd_o = 19'h1234 and fsm_is_ref_o = 0.
- Urgent refresh blocks the host:
  - Stimulus: 4 ticks after init with cmd_fsm stalled (fsm_ready_i = 0), then host_valid_i held high.
  - Required: host_ready_o = 0 while pending >= 4.
  - Required: REF_CMD is issued first, and ref_pending_o goes 4 -> 3 on the ready handshake.
- Saturation and overrun:
  - Stimulus: 10 ticks with fsm_ready_i = 0.
  - Required: ref_pending_o = 8 and ref_overrun_o = 1.
  - Required: ref_overrun_o stays 1 after draining to 0, until rst_i.
- Simultaneous tick and refresh issue:
  - Stimulus: tick in the same cycle as a refresh handshake, pending = 2.
  - Required: pending stays 2.
- Valid stability and reset mid-command:
  - Stimulus: hold fsm_ready_i = 0 for 5 cycles.
  - Required: fsm_valid_o and fsm_cmd_o stable throughout.
  - Then assert rst_i asynchronously mid-WAIT_DONE.
  - Required: all outputs 0 immediately, state IDLE.
- Opportunistic refresh versus host:
  - Stimulus: pending = 1 with no host_valid_i.
  - Required: REF issued.
  - Stimulus: pending = 1 with host_valid_i = 1.
  - Required: host command issued first, then REF after fsm_done_i.

Source files
------------

// File: rtl/rpc_config_path_pkg.sv
// rpc_config_path_pkg: refresh scheduler encodings, state type and parameter defaults.
package rpc_config_path_pkg;
    localparam int CMD_WIDTH_DEF     = 19;
    localparam int MAX_POSTPONE_DEF  = 8;
    localparam int URGENT_THRESH_DEF = 4;
    localparam logic [CMD_WIDTH_DEF-1:0] REF_CMD = 19'h4_0001;
    typedef logic [1:0] refresh_sched_state_t;
    localparam refresh_sched_state_t ST_IDLE      = 2'd0;
    localparam refresh_sched_state_t ST_ISSUE     = 2'd1;
    localparam refresh_sched_state_t ST_WAIT_DONE = 2'd2;
endpackage

// File: rtl/rpc_pending_cnt.sv
// rpc_pending_cnt: saturating up/down pending-refresh counter with sticky overrun flag.
module rpc_pending_cnt
    import rpc_config_path_pkg::*;
#(
    parameter int CNT_WIDTH    = 4,
    parameter int MAX_POSTPONE = MAX_POSTPONE_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 overrun
);
    localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(MAX_POSTPONE);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (inc && !dec) begin
            if (cnt == MAX) overrun <= 1'b1;
            else cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/rpc_refresh_scheduler.sv
// rpc_refresh_scheduler: arbitrates host and refresh commands onto the cmd_fsm port.
// Optional issue counters enabled by RPC_REFRESH_SCHED_STATS_EN.
module rpc_refresh_scheduler
    import rpc_config_path_pkg::*;
#(
    parameter int CMD_WIDTH     = CMD_WIDTH_DEF,
    parameter int CNT_WIDTH     = 4,
    parameter int MAX_POSTPONE  = MAX_POSTPONE_DEF,
    parameter int URGENT_THRESH = URGENT_THRESH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_done_i,
    input  logic                 ref_tick_i,
    input  logic                 host_valid_i,
    input  logic [CMD_WIDTH-1:0] host_cmd_i,
    output logic                 host_ready_o,
    output logic                 fsm_valid_o,
    output logic [CMD_WIDTH-1:0] fsm_cmd_o,
    output logic                 fsm_is_ref_o,
    input  logic                 fsm_ready_i,
    input  logic                 fsm_done_i,
    output logic [CNT_WIDTH-1:0] ref_pending_o,
    output logic                 ref_overrun_o
`ifdef RPC_REFRESH_SCHED_STATS_EN
    ,
    output logic [15:0]          host_issued_o,
    output logic [15:0]          ref_issued_o
`endif
);
    refresh_sched_state_t state;
    logic init_q, urgent, host_hs, issue_hs;
    assign urgent       = ref_pending_o >= CNT_WIDTH'(URGENT_THRESH);
    assign host_ready_o = (state == ST_IDLE) && init_q && !urgent;
    assign host_hs      = host_valid_i && host_ready_o;
    assign fsm_valid_o  = state == ST_ISSUE;
    assign issue_hs     = fsm_valid_o && fsm_ready_i;

    rpc_pending_cnt #(.CNT_WIDTH(CNT_WIDTH), .MAX_POSTPONE(MAX_POSTPONE)) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc     (ref_tick_i && init_q),
        .dec     (issue_hs && fsm_is_ref_o),
        .cnt     (ref_pending_o),
        .overrun (ref_overrun_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            init_q       <= 1'b0;
            fsm_cmd_o    <= '0;
            fsm_is_ref_o <= 1'b0;
        end else begin
            if (init_done_i) init_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // urgency beats the host; idle refresh only fills otherwise empty slots
                    if (urgent || (!host_hs && init_q && ref_pending_o != '0)) begin
                        fsm_cmd_o    <= CMD_WIDTH'(REF_CMD);
                        fsm_is_ref_o <= 1'b1;
                        state        <= ST_ISSUE;
                    end else if (host_hs) begin
                        fsm_cmd_o    <= host_cmd_i;
                        fsm_is_ref_o <= 1'b0;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE:     if (fsm_ready_i) state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (fsm_done_i) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

`ifdef RPC_REFRESH_SCHED_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            host_issued_o <= '0;
            ref_issued_o  <= '0;
        end else if (issue_hs) begin
            if (fsm_is_ref_o) ref_issued_o <= ref_issued_o + 16'd1;
            else host_issued_o <= host_issued_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rpc_refresh_scheduler.sv
// tb_rpc_refresh_scheduler: vector table plus directed sequences with an issue scoreboard.
module tb_rpc_refresh_scheduler;
    import rpc_config_path_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0, init_done = 1'b0, ref_tick = 1'b0, host_valid = 1'b0;
    logic fsm_ready = 1'b0, fsm_done = 1'b0;
    logic [18:0] host_cmd = '0;
    logic host_ready, fsm_valid, fsm_is_ref, ref_overrun;
    logic [18:0] fsm_cmd;
    logic [3:0] ref_pending;
`ifdef RPC_REFRESH_SCHED_STATS_EN
    logic [15:0] host_issued, ref_issued;
`endif
    int checks = 0, errors = 0;
    typedef struct {logic [18:0] cmd; logic is_ref;} exp_t;
    exp_t sb[$];
    localparam logic [18:0] REF = REF_CMD;

    rpc_refresh_scheduler dut (
        .clk_i(clk), .rst_i(rst), .init_done_i(init_done), .ref_tick_i(ref_tick),
        .host_valid_i(host_valid), .host_cmd_i(host_cmd), .host_ready_o(host_ready),
        .fsm_valid_o(fsm_valid), .fsm_cmd_o(fsm_cmd), .fsm_is_ref_o(fsm_is_ref),
        .fsm_ready_i(fsm_ready), .fsm_done_i(fsm_done),
        .ref_pending_o(ref_pending), .ref_overrun_o(ref_overrun)
`ifdef RPC_REFRESH_SCHED_STATS_EN
        , .host_issued_o(host_issued), .ref_issued_o(ref_issued)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ref_tick = 1'b1;
            cyc();
            ref_tick = 1'b0;
        end
    endtask

    task automatic init_pulse();
        init_done = 1'b1;
        cyc();
        init_done = 1'b0;
    endtask

    task automatic do_reset();
        {init_done, ref_tick, host_valid, fsm_ready, fsm_done} = '0;
        rst = 1'b1;
        sb.delete();
        cyc();
        chk("rst_valid", fsm_valid, 0);
        chk("rst_cmd", fsm_cmd, 0);
        chk("rst_is_ref", fsm_is_ref, 0);
        chk("rst_pending", ref_pending, 0);
        chk("rst_overrun", ref_overrun, 0);
        chk("rst_host_ready", host_ready, 0);
        rst = 1'b0;
        cyc();
    endtask

    // Expects n refresh issues; cmd_fsm answers instantly until the backlog is empty.
    task automatic drain(input int n);
        int k;
        for (int i = 0; i < n; i++) sb.push_back('{REF, 1'b1});
        fsm_ready = 1'b1;
        fsm_done  = 1'b1;
        k = 0;
        while (ref_pending != 0 && k < 60) begin
            cyc();
            k++;
        end
        chk("drain_in_time", k < 60, 1);
        fsm_ready = 1'b0;
        cyc();
        fsm_done = 1'b0;
        cyc();
        chk("drain_pending", ref_pending, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && fsm_valid && fsm_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got cmd %0h is_ref %0b expected no issue", fsm_cmd, fsm_is_ref);
            end else begin
                e = sb.pop_front();
                chk("sb_cmd", fsm_cmd, e.cmd);
                chk("sb_is_ref", fsm_is_ref, e.is_ref);
            end
        end
    end

    typedef struct {int n_ticks; logic [3:0] pend; logic ovr; logic hrdy;} vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{0, 4'd0, 1'b0, 1'b1};
        tbl[1] = '{3, 4'd3, 1'b0, 1'b0};
        tbl[2] = '{5, 4'd8, 1'b0, 1'b0};
        tbl[3] = '{1, 4'd8, 1'b1, 1'b0};
        tbl[4] = '{1, 4'd8, 1'b1, 1'b0};

        // ticks ignored before init, then first host command
        do_reset();
        ticks(3);
        chk("preinit_pending", ref_pending, 0);
        chk("preinit_host_ready", host_ready, 0);
        host_valid = 1'b1;
        host_cmd   = 19'h1234;
        init_pulse();
        chk("init_host_ready", host_ready, 1);
        chk("init_no_valid", fsm_valid, 0);
        sb.push_back('{19'h1234, 1'b0});
        cyc();
        host_valid = 1'b0;
        chk("lat_valid", fsm_valid, 1);
        chk("lat_cmd", fsm_cmd, 19'h1234);
        chk("lat_is_ref", fsm_is_ref, 0);
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        chk("wait_valid_low", fsm_valid, 0);
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        chk("idle_host_ready", host_ready, 1);

        // urgent refresh blocks host
        ticks(4);
        host_valid = 1'b1;
        host_cmd   = 19'h0abc;
        chk("urg_pending", ref_pending, 4);
        chk("urg_host_ready", host_ready, 0);
        chk("urg_is_ref", fsm_is_ref, 1);
        chk("urg_cmd", fsm_cmd, REF);
        cyc();
        chk("urg_host_ready2", host_ready, 0);
        sb.push_back('{REF, 1'b1});
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        chk("urg_dec", ref_pending, 3);
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        chk("below_urg_host_ready", host_ready, 1);
        sb.push_back('{19'h0abc, 1'b0});
        cyc();
        host_valid = 1'b0;
        chk("host_after_urg_valid", fsm_valid, 1);
        chk("host_after_urg_is_ref", fsm_is_ref, 0);
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        drain(3);

        // saturation and sticky overrun
        do_reset();
        init_pulse();
        for (int i = 0; i < 5; i++) begin
            ticks(tbl[i].n_ticks);
            chk($sformatf("tbl%0d_pending", i), ref_pending, tbl[i].pend);
            chk($sformatf("tbl%0d_overrun", i), ref_overrun, tbl[i].ovr);
            chk($sformatf("tbl%0d_host_ready", i), host_ready, tbl[i].hrdy);
        end
        drain(8);
        chk("ovr_sticky", ref_overrun, 1);
        do_reset();

        // tick coincident with refresh handshake
        init_pulse();
        ticks(2);
        chk("sim_pre_pending", ref_pending, 2);
        chk("sim_pre_is_ref", fsm_is_ref, 1);
        sb.push_back('{REF, 1'b1});
        ref_tick  = 1'b1;
        fsm_ready = 1'b1;
        cyc();
        ref_tick  = 1'b0;
        fsm_ready = 1'b0;
        chk("sim_pending", ref_pending, 2);
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        drain(2);

        // valid stability under stall, async reset in WAIT_DONE
        host_valid = 1'b1;
        host_cmd   = 19'h5a5a5;
        cyc();
        host_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), fsm_valid, 1);
            chk($sformatf("stall%0d_cmd", i), fsm_cmd, 19'h5a5a5);
            cyc();
        end
        sb.push_back('{19'h5a5a5, 1'b0});
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", fsm_valid, 0);
        chk("arst_cmd", fsm_cmd, 0);
        chk("arst_is_ref", fsm_is_ref, 0);
        chk("arst_host_ready", host_ready, 0);
        chk("arst_pending", ref_pending, 0);
        sb.delete();
        cyc();
        rst = 1'b0;
        cyc();
        chk("arst_idle_no_valid", fsm_valid, 0);

        // opportunistic refresh, then host preferred over single pending refresh
        init_pulse();
        ticks(1);
        cyc();
        chk("opp_valid", fsm_valid, 1);
        chk("opp_is_ref", fsm_is_ref, 1);
        sb.push_back('{REF, 1'b1});
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        chk("opp_pending", ref_pending, 0);
        host_valid = 1'b1;
        host_cmd   = 19'h00777;
        sb.push_back('{19'h00777, 1'b0});
        sb.push_back('{REF, 1'b1});
        ticks(1);
        host_valid = 1'b0;
        chk("pref_pending", ref_pending, 1);
        chk("pref_is_ref", fsm_is_ref, 0);
        chk("pref_cmd", fsm_cmd, 19'h00777);
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        chk("pref_wait_valid", fsm_valid, 0);
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        cyc();
        chk("pref_ref_valid", fsm_valid, 1);
        chk("pref_ref_is_ref", fsm_is_ref, 1);
        fsm_ready = 1'b1;
        cyc();
        fsm_ready = 1'b0;
        fsm_done = 1'b1;
        cyc();
        fsm_done = 1'b0;
        chk("end_pending", ref_pending, 0);
        chk("sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
